// File: rtl/execute_stage_if.sv
// Fetch/writeback-facing bus of the execute stage: instruction in, redirect out,
// stage-3 register write-back in, MEM/WB pipeline register out.
interface execute_stage_if #(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       instruction_EX;
    logic [PC_W-1:0]   pc_EX;
    logic              wb_we;
    logic [4:0]        wb_waddr;
    logic [DATA_W-1:0] wb_wdata;

    logic [1:0]        pc_src_EX;
    logic [PC_W-1:0]   branch_addr_EX;
    logic [PC_W-1:0]   jtype_addr_EX;
    logic [PC_W-1:0]   reg_addr_EX;
    logic              stall_EX;

    logic [DATA_W-1:0] alu_result_MEM;
    logic [DATA_W-1:0] store_data_MEM;
    logic [4:0]        rd_MEM;
    logic              reg_write_MEM;
    logic              mem_read_MEM;
    logic              mem_write_MEM;

    modport master (
        output instruction_EX, pc_EX, wb_we, wb_waddr, wb_wdata,
        input  pc_src_EX, branch_addr_EX, jtype_addr_EX, reg_addr_EX, stall_EX,
        input  alu_result_MEM, store_data_MEM, rd_MEM, reg_write_MEM,
        input  mem_read_MEM, mem_write_MEM
    );

    modport slave (
        input  instruction_EX, pc_EX, wb_we, wb_waddr, wb_wdata,
        output pc_src_EX, branch_addr_EX, jtype_addr_EX, reg_addr_EX, stall_EX,
        output alu_result_MEM, store_data_MEM, rd_MEM, reg_write_MEM,
        output mem_read_MEM, mem_write_MEM
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: decode, 32x32 register file with write-through bypass,
// ALU, branch/jump resolution and the MEM/WB pipeline register.
module execute_stage #(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    localparam int unsigned REG_N = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_JR     = 2'b11;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = bus.instruction_EX[31:26];
    assign rs     = bus.instruction_EX[25:21];
    assign rt     = bus.instruction_EX[20:16];
    assign rd     = bus.instruction_EX[15:11];
    assign shamt  = bus.instruction_EX[10:6];
    assign funct  = bus.instruction_EX[5:0];
    assign imm    = bus.instruction_EX[15:0];

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] rs_val, rt_val, imm_sx, imm_zx, link_val;
    logic [PC_W-1:0]   pc_inc;

    // Stage-3 write in the same cycle is visible to this cycle's read; $0 is hardwired
    assign rs_val = (rs == 5'd0) ? '0 :
                    (bus.wb_we && bus.wb_waddr == rs) ? bus.wb_wdata : regs[rs];
    assign rt_val = (rt == 5'd0) ? '0 :
                    (bus.wb_we && bus.wb_waddr == rt) ? bus.wb_wdata : regs[rt];

    assign imm_sx   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zx   = {{(DATA_W-16){1'b0}}, imm};
    assign pc_inc   = bus.pc_EX + PC_W'(1);
    assign link_val = DATA_W'(pc_inc);

    logic [DATA_W-1:0] alu_c;
    logic [4:0]        dst_c;
    logic              wr_c, mr_c, mw_c, wr_eff_c;
    logic [1:0]        src_c;

    // Decode and ALU; anything unrecognised falls through as a nop
    always_comb begin
        alu_c = '0;
        dst_c = 5'd0;
        wr_c  = 1'b0;
        mr_c  = 1'b0;
        mw_c  = 1'b0;
        src_c = SRC_SEQ;
        case (opcode)
            OP_RTYPE: begin
                dst_c = rd;
                wr_c  = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_c = rs_val + rt_val;
                    FN_SUB, FN_SUBU: alu_c = rs_val - rt_val;
                    FN_AND:  alu_c = rs_val & rt_val;
                    FN_OR:   alu_c = rs_val | rt_val;
                    FN_XOR:  alu_c = rs_val ^ rt_val;
                    FN_NOR:  alu_c = ~(rs_val | rt_val);
                    FN_SLT:  alu_c = DATA_W'($signed(rs_val) < $signed(rt_val));
                    FN_SLTU: alu_c = DATA_W'(rs_val < rt_val);
                    FN_SLL:  alu_c = rt_val << shamt;
                    FN_SRL:  alu_c = rt_val >> shamt;
                    FN_SRA:  alu_c = DATA_W'($signed(rt_val) >>> shamt);
                    FN_JR: begin
                        wr_c  = 1'b0;
                        src_c = SRC_JR;
                    end
                    FN_JALR: begin
                        alu_c = link_val;
                        src_c = SRC_JR;
                    end
                    default: wr_c = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin alu_c = rs_val + imm_sx; dst_c = rt; wr_c = 1'b1; end
            OP_SLTI:  begin alu_c = DATA_W'($signed(rs_val) < $signed(imm_sx)); dst_c = rt; wr_c = 1'b1; end
            OP_SLTIU: begin alu_c = DATA_W'(rs_val < imm_sx); dst_c = rt; wr_c = 1'b1; end
            OP_ANDI:  begin alu_c = rs_val & imm_zx; dst_c = rt; wr_c = 1'b1; end
            OP_ORI:   begin alu_c = rs_val | imm_zx; dst_c = rt; wr_c = 1'b1; end
            OP_XORI:  begin alu_c = rs_val ^ imm_zx; dst_c = rt; wr_c = 1'b1; end
            OP_LUI:   begin alu_c = {imm, {(DATA_W-16){1'b0}}}; dst_c = rt; wr_c = 1'b1; end
            OP_LW:    begin alu_c = rs_val + imm_sx; dst_c = rt; wr_c = 1'b1; mr_c = 1'b1; end
            OP_SW:    begin alu_c = rs_val + imm_sx; mw_c = 1'b1; end
            OP_BEQ:   src_c = (rs_val == rt_val) ? SRC_BRANCH : SRC_SEQ;
            OP_BNE:   src_c = (rs_val != rt_val) ? SRC_BRANCH : SRC_SEQ;
            OP_J:     src_c = SRC_JUMP;
            OP_JAL:   begin alu_c = link_val; dst_c = 5'd31; wr_c = 1'b1; src_c = SRC_JUMP; end
            default:  ;
        endcase
    end

    assign wr_eff_c = wr_c && (dst_c != 5'd0);

    // Redirect bus is sampled by fetch on the same edge
    assign bus.pc_src_EX      = rst ? SRC_SEQ : src_c;
    assign bus.branch_addr_EX = pc_inc + imm_sx[PC_W-1:0];
    assign bus.jtype_addr_EX  = bus.instruction_EX[PC_W-1:0];
    assign bus.reg_addr_EX    = rs_val[PC_W-1:0];
    assign bus.stall_EX       = 1'b0;

    // Register file write port and MEM/WB pipeline register; reset discards a coincident write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
            bus.alu_result_MEM <= '0;
            bus.store_data_MEM <= '0;
            bus.rd_MEM         <= 5'd0;
            bus.reg_write_MEM  <= 1'b0;
            bus.mem_read_MEM   <= 1'b0;
            bus.mem_write_MEM  <= 1'b0;
        end else begin
            if (bus.wb_we && bus.wb_waddr != 5'd0) regs[bus.wb_waddr] <= bus.wb_wdata;
            bus.alu_result_MEM <= alu_c;
            bus.store_data_MEM <= rt_val;
            bus.rd_MEM         <= wr_eff_c ? dst_c : 5'd0;
            bus.reg_write_MEM  <= wr_eff_c;
            bus.mem_read_MEM   <= mr_c;
            bus.mem_write_MEM  <= mw_c;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Execute-stage bench: mnemonic-level reference model with a per-cycle compare
// process, directed scenarios pinned by literal values, then random traffic.
module tb_execute_stage;
    logic clk;
    logic rst;

    execute_stage_if #(.PC_W(10), .DATA_W(32)) bus();

    execute_stage #(.PC_W(10), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_SRA, M_JR, M_JALR, M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI,
        M_SLTI, M_SLTIU, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_NOP, M_BAD
    } mn_t;

    typedef struct packed {
        logic [1:0]  src;
        logic [9:0]  baddr;
        logic [9:0]  jaddr;
        logic [9:0]  raddr;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mregs [32];
    exp_t ec, em, pend;
    logic p_rst, p_we;
    logic [4:0] p_wa;
    logic [31:0] p_wd;
    bit chk_en = 1'b0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input mn_t m, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [15:0] imm, input logic [25:0] tgt);
        case (m)
            M_ADD:   return {6'h00, rs, rt, rd, sh, 6'h20};
            M_ADDU:  return {6'h00, rs, rt, rd, sh, 6'h21};
            M_SUB:   return {6'h00, rs, rt, rd, sh, 6'h22};
            M_SUBU:  return {6'h00, rs, rt, rd, sh, 6'h23};
            M_AND:   return {6'h00, rs, rt, rd, sh, 6'h24};
            M_OR:    return {6'h00, rs, rt, rd, sh, 6'h25};
            M_XOR:   return {6'h00, rs, rt, rd, sh, 6'h26};
            M_NOR:   return {6'h00, rs, rt, rd, sh, 6'h27};
            M_SLT:   return {6'h00, rs, rt, rd, sh, 6'h2a};
            M_SLTU:  return {6'h00, rs, rt, rd, sh, 6'h2b};
            M_SLL:   return {6'h00, rs, rt, rd, sh, 6'h00};
            M_SRL:   return {6'h00, rs, rt, rd, sh, 6'h02};
            M_SRA:   return {6'h00, rs, rt, rd, sh, 6'h03};
            M_JR:    return {6'h00, rs, rt, rd, sh, 6'h08};
            M_JALR:  return {6'h00, rs, rt, rd, sh, 6'h09};
            M_ADDI:  return {6'h08, rs, rt, imm};
            M_ADDIU: return {6'h09, rs, rt, imm};
            M_SLTI:  return {6'h0a, rs, rt, imm};
            M_SLTIU: return {6'h0b, rs, rt, imm};
            M_ANDI:  return {6'h0c, rs, rt, imm};
            M_ORI:   return {6'h0d, rs, rt, imm};
            M_XORI:  return {6'h0e, rs, rt, imm};
            M_LUI:   return {6'h0f, rs, rt, imm};
            M_LW:    return {6'h23, rs, rt, imm};
            M_SW:    return {6'h2b, rs, rt, imm};
            M_BEQ:   return {6'h04, rs, rt, imm};
            M_BNE:   return {6'h05, rs, rt, imm};
            M_J:     return {6'h02, tgt};
            M_JAL:   return {6'h03, tgt};
            M_NOP:   return 32'h0;
            default: return sh[0] ? {6'h00, rs, rt, rd, sh, 6'h01} : {6'h3e, rs, rt, imm};
        endcase
    endfunction

    function automatic logic [31:0] rf(input logic [4:0] a, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    // Architectural meaning of each mnemonic, independent of how the hardware decodes it
    function automatic exp_t model(input mn_t m, input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [9:0] pc);
        exp_t e;
        logic [31:0] sx, zx;
        int sh, dest;
        e = '0;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        sh = int'(ins[10:6]);
        dest = -1;
        e.baddr = 10'((int'(pc) + 1 + int'($signed(sx))) & 1023);
        e.jaddr = ins[9:0];
        e.raddr = a[9:0];
        e.sd    = b;
        case (m)
            M_ADD, M_ADDU: begin e.alu = a + b; dest = int'(ins[15:11]); end
            M_SUB, M_SUBU: begin e.alu = a - b; dest = int'(ins[15:11]); end
            M_AND:  begin e.alu = a & b; dest = int'(ins[15:11]); end
            M_OR:   begin e.alu = a | b; dest = int'(ins[15:11]); end
            M_XOR:  begin e.alu = a ^ b; dest = int'(ins[15:11]); end
            M_NOR:  begin e.alu = ~(a | b); dest = int'(ins[15:11]); end
            M_SLT:  begin e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dest = int'(ins[15:11]); end
            M_SLTU: begin e.alu = (a < b) ? 32'd1 : 32'd0; dest = int'(ins[15:11]); end
            M_SLL:  begin e.alu = b << sh; dest = int'(ins[15:11]); end
            M_SRL:  begin e.alu = b >> sh; dest = int'(ins[15:11]); end
            M_SRA:  begin e.alu = 32'($signed(b) >>> sh); dest = int'(ins[15:11]); end
            M_JR:   e.src = 2'b11;
            M_JALR: begin e.src = 2'b11; e.alu = 32'((int'(pc) + 1) % 1024); dest = int'(ins[15:11]); end
            M_ADDI, M_ADDIU: begin e.alu = a + sx; dest = int'(ins[20:16]); end
            M_ANDI: begin e.alu = a & zx; dest = int'(ins[20:16]); end
            M_ORI:  begin e.alu = a | zx; dest = int'(ins[20:16]); end
            M_XORI: begin e.alu = a ^ zx; dest = int'(ins[20:16]); end
            M_SLTI: begin e.alu = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; dest = int'(ins[20:16]); end
            M_SLTIU: begin e.alu = (a < sx) ? 32'd1 : 32'd0; dest = int'(ins[20:16]); end
            M_LUI:  begin e.alu = {ins[15:0], 16'h0}; dest = int'(ins[20:16]); end
            M_LW:   begin e.alu = a + sx; e.mr = 1'b1; dest = int'(ins[20:16]); end
            M_SW:   begin e.alu = a + sx; e.mw = 1'b1; end
            M_BEQ:  e.src = (a == b) ? 2'b01 : 2'b00;
            M_BNE:  e.src = (a != b) ? 2'b01 : 2'b00;
            M_J:    e.src = 2'b10;
            M_JAL:  begin e.src = 2'b10; e.alu = 32'((int'(pc) + 1) % 1024); dest = 31; end
            default: ;
        endcase
        if (dest > 0) begin
            e.rw = 1'b1;
            e.rd = 5'(dest);
        end
        return e;
    endfunction

    // One cycle: retire the previous cycle's effects into the model, then present a new instruction
    task automatic cyc(input logic r, input mn_t m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [9:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] ins;
        exp_t e;
        @(posedge clk);
        #1;
        if (p_rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else if (p_we && p_wa != 5'd0) begin
            mregs[p_wa] = p_wd;
        end
        em = p_rst ? '0 : pend;
        ins = enc(m, rs, rt, rd, sh, imm, tgt);
        e = model(m, ins, rf(ins[25:21], we, wa, wd), rf(ins[20:16], we, wa, wd), pc);
        pend = e;
        if (r) e.src = 2'b00;
        ec = e;
        rst = r;
        bus.instruction_EX = ins;
        bus.pc_EX = pc;
        bus.wb_we = we;
        bus.wb_waddr = wa;
        bus.wb_wdata = wd;
        p_rst = r;
        p_we = we;
        p_wa = wa;
        p_wd = wd;
        #1;
    endtask

    task automatic op(input mn_t m, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm, input logic [9:0] pc);
        cyc(1'b0, m, rs, rt, rd, sh, imm, 26'h0, pc, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 10'd0, 1'b1, a, d);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_src", 32'(bus.pc_src_EX), 32'(ec.src));
            check("branch_addr", 32'(bus.branch_addr_EX), 32'(ec.baddr));
            check("jtype_addr", 32'(bus.jtype_addr_EX), 32'(ec.jaddr));
            check("reg_addr", 32'(bus.reg_addr_EX), 32'(ec.raddr));
            check("stall", 32'(bus.stall_EX), 32'h0);
            check("reg_write", 32'(bus.reg_write_MEM), 32'(em.rw));
            check("mem_read", 32'(bus.mem_read_MEM), 32'(em.mr));
            check("mem_write", 32'(bus.mem_write_MEM), 32'(em.mw));
            if (em.rw || em.mr || em.mw) check("alu_result", bus.alu_result_MEM, em.alu);
            if (em.rw) check("rd", 32'(bus.rd_MEM), 32'(em.rd));
            if (em.mw) check("store_data", bus.store_data_MEM, em.sd);
        end
    end

    initial begin
        mn_t m;
        logic [31:0] wd;
        rst = 1'b1;
        bus.instruction_EX = 32'h0;
        bus.pc_EX = 10'd0;
        bus.wb_we = 1'b0;
        bus.wb_waddr = 5'd0;
        bus.wb_wdata = 32'h0;
        p_rst = 1'b1; p_we = 1'b0; p_wa = 5'd0; p_wd = 32'h0;
        pend = '0; ec = '0; em = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

        // Reset, with a coincident write that must be discarded
        cyc(1'b1, M_NOP, 0, 0, 0, 0, 16'h0, 26'h0, 10'd0, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, M_BEQ, 0, 0, 0, 0, 16'h5, 26'h0, 10'd3, 1'b1, 5'd9, 32'h1234_5678);
        chk_en = 1'b1;
        check("rst_pc_src", 32'(bus.pc_src_EX), 32'h0);
        op(M_ADDU, 5'd9, 5'd0, 5'd3, 0, 16'h0, 10'd0);
        check("rst_alu", bus.alu_result_MEM, 32'h0);
        check("rst_rd", 32'(bus.rd_MEM), 32'h0);
        check("rst_rw", 32'(bus.reg_write_MEM), 32'h0);
        check("rst_mw", 32'(bus.mem_write_MEM), 32'h0);
        for (int i = 1; i < 32; i++) op(M_ADDU, 5'(i), 5'd0, 5'd1, 0, 16'h0, 10'd0);

        // Write-through bypass
        cyc(1'b0, M_ADD, 5'd1, 5'd1, 5'd2, 0, 16'h0, 26'h0, 10'd0, 1'b1, 5'd1, 32'd5);
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        check("bypass_alu", bus.alu_result_MEM, 32'd10);
        check("bypass_rd", 32'(bus.rd_MEM), 32'd2);
        check("bypass_rw", 32'(bus.reg_write_MEM), 32'd1);

        // Branches
        wb(5'd3, 32'd7);
        wb(5'd4, 32'd7);
        op(M_BEQ, 5'd3, 5'd4, 0, 0, 16'hFFFD, 10'd20);
        check("beq_taken_src", 32'(bus.pc_src_EX), 32'd1);
        check("beq_addr", 32'(bus.branch_addr_EX), 32'd18);
        wb(5'd4, 32'd8);
        op(M_BEQ, 5'd3, 5'd4, 0, 0, 16'hFFFD, 10'd20);
        check("beq_nt_src", 32'(bus.pc_src_EX), 32'd0);

        // jal / jr
        cyc(1'b0, M_JAL, 0, 0, 0, 0, 16'h0, 26'h155, 10'd7, 1'b0, 5'd0, 32'h0);
        check("jal_src", 32'(bus.pc_src_EX), 32'd2);
        check("jal_addr", 32'(bus.jtype_addr_EX), 32'h155);
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        check("jal_rd", 32'(bus.rd_MEM), 32'd31);
        check("jal_link", bus.alu_result_MEM, 32'd8);
        wb(5'd5, 32'hFFFF_F3FF);
        op(M_JR, 5'd5, 0, 0, 0, 16'h0, 10'd0);
        check("jr_src", 32'(bus.pc_src_EX), 32'd3);
        check("jr_addr", 32'(bus.reg_addr_EX), 32'h3FF);

        // Loads and stores
        wb(5'd6, 32'd100);
        wb(5'd7, 32'hDEAD_BEEF);
        op(M_SW, 5'd6, 5'd7, 0, 0, 16'hFFFC, 10'd0);
        op(M_LW, 5'd6, 5'd8, 0, 0, 16'h0, 10'd0);
        check("sw_addr", bus.alu_result_MEM, 32'd96);
        check("sw_mw", 32'(bus.mem_write_MEM), 32'd1);
        check("sw_data", bus.store_data_MEM, 32'hDEAD_BEEF);
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        check("lw_mr", 32'(bus.mem_read_MEM), 32'd1);
        check("lw_rw", 32'(bus.reg_write_MEM), 32'd1);

        // Edge cases: $0, signed/unsigned compare, arithmetic shift
        wb(5'd0, 32'h0000_1234);
        op(M_ADDU, 5'd0, 5'd0, 5'd9, 0, 16'h0, 10'd0);
        op(M_ADDIU, 5'd0, 5'd1, 0, 0, 16'hFFFF, 10'd0);
        check("zero_reg", bus.alu_result_MEM, 32'h0);
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        check("addiu_m1", bus.alu_result_MEM, 32'hFFFF_FFFF);
        wb(5'd1, 32'hFFFF_FFFF);
        op(M_SLTU, 5'd1, 5'd0, 5'd2, 0, 16'h0, 10'd0);
        op(M_SLT, 5'd1, 5'd0, 5'd2, 0, 16'h0, 10'd0);
        check("sltu", bus.alu_result_MEM, 32'd0);
        wb(5'd10, 32'h8000_0000);
        check("slt", bus.alu_result_MEM, 32'd1);
        op(M_SRA, 5'd0, 5'd10, 5'd11, 5'd4, 16'h0, 10'd0);
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        check("sra", bus.alu_result_MEM, 32'hF800_0000);

        // Reset during a taken branch
        wb(5'd3, 32'd7);
        wb(5'd4, 32'd7);
        cyc(1'b1, M_BEQ, 5'd3, 5'd4, 0, 0, 16'h0002, 26'h0, 10'd40, 1'b0, 5'd0, 32'h0);
        check("rst_branch_src", 32'(bus.pc_src_EX), 32'd0);
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        check("rst_branch_rw", 32'(bus.reg_write_MEM), 32'd0);
        check("rst_branch_alu", bus.alu_result_MEM, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            m = mn_t'($urandom_range(0, 30));
            case ($urandom_range(0, 4))
                0: wd = 32'h8000_0000;
                1: wd = 32'hFFFF_FFFF;
                2: wd = 32'($urandom_range(0, 3));
                default: wd = $urandom;
            endcase
            cyc(($urandom_range(0, 63) == 0), m,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                5'($urandom), 16'($urandom), 26'($urandom), 10'($urandom),
                1'($urandom), 5'($urandom_range(0, 7)), wd);
        end
        op(M_NOP, 0, 0, 0, 0, 16'h0, 10'd0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
